regfile_write_arbiter: RTL and testbench

Shares the register file's single write port (WE3/A3/WD3) among NUM_REQ writeback requesters using a round-robin valid/ready handshake. Also contains an init sequencer that rewrites all 32 registers with their index values, restoring the power-on contents, without a reset of the register file. It sits between the writeback sources (ALU, load unit, debug port) and register_file. All register file write traffic passes through this block.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, FSM encoding and write payload for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    ARB  = 1'b0,
    INIT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic found;

  // Offset k from ptr is tried in order; the first live requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[i] && (((32'(ptr) + k) % N) == i)) begin
          gnt[i]  = 1'b1;
          gnt_idx = PW'(i);
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register-file write port, plus an init sequencer that
// rewrites every register with its own index.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter bit          ZERO_X0 = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*REG_DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           init_start,
  output logic                           init_busy,
  output logic                           WE3,
  output logic [REG_ADDR_W-1:0]          A3,
  output logic [REG_DATA_W-1:0]          WD3
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam logic [REG_ADDR_W-1:0] LAST_ADDR = REG_ADDR_W'(NUM_REGS - 1);
  localparam logic [PTR_W-1:0]      LAST_REQ  = PTR_W'(NUM_REQ - 1);

  arb_state_t            state_q, state_d;
  logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  we_q, we_d;
  rf_wr_t                wr_q, wr_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [PTR_W-1:0]      gnt_idx;
  rf_wr_t                sel_wr;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Payload of the granted requester.
  always_comb begin
    sel_wr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_wr.addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        sel_wr.data = req_data[i*REG_DATA_W +: REG_DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    we_d      = 1'b0;
    wr_d      = wr_q;
    req_ready = '0;
    case (state_q)
      ARB: begin
        // init_start outranks every requester; nothing is granted while rst is high.
        if (init_start) begin
          state_d = INIT;
          cnt_d   = '0;
        end else if (!rst) begin
          req_ready = gnt;
          if (|gnt) begin
            rr_ptr_d = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + PTR_W'(1);
            wr_d     = sel_wr;
            we_d     = !(ZERO_X0 && (sel_wr.addr == '0));
          end
        end
      end
      INIT: begin
        wr_d.addr = cnt_q;
        wr_d.data = REG_DATA_W'(cnt_q);
        we_d      = !(ZERO_X0 && (cnt_q == '0));
        cnt_d     = cnt_q + REG_ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      wr_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      wr_q     <= wr_d;
    end
  end

  assign init_busy = (state_q == INIT);
  assign WE3       = we_q;
  assign A3        = wr_q.addr;
  assign WD3       = wr_q.data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: a reference model predicts grants and writes, a monitor checks the write port.
module tb_regfile_write_arbiter;

  localparam int NREQ = 3;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req_valid = '0, req_ready;
  logic [14:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic        init_start = 1'b0, init_busy, WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  logic [2:0]  z_valid = '0, z_ready;
  logic [14:0] z_addr = '0;
  logic [95:0] z_data = '0;
  logic        z_init = 1'b0, z_busy, z_we;
  logic [4:0]  z_a3;
  logic [31:0] z_wd3;

  regfile_write_arbiter #(.NUM_REQ(3), .ZERO_X0(1'b0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .init_start(init_start), .init_busy(init_busy),
    .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  regfile_write_arbiter #(.NUM_REQ(3), .ZERO_X0(1'b1)) dut_z (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_addr(z_addr), .req_data(z_data),
    .req_ready(z_ready), .init_start(z_init), .init_busy(z_busy),
    .WE3(z_we), .A3(z_a3), .WD3(z_wd3)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0, n_fail = 0, cyc = 0;
  int   we_cnt = 0, busy_cnt = 0;
  bit   model_ok = 1'b0;
  exp_t sb[$];
  int   glog[$];

  // Requester side: a pending write stays presented until it is granted.
  bit          pend_v[NREQ];
  logic [4:0]  pend_a[NREQ];
  logic [31:0] pend_d[NREQ];
  bit          init_go = 1'b0;

  // Reference state: arbitration pointer and init progress.
  int          m_ptr = 0, m_cnt = 0;
  bit          m_init = 1'b0;
  logic [31:0] exp_rf[32];
  logic [31:0] dut_rf[32];

  bit          z_chk = 1'b0;
  logic [2:0]  z_exp_rdy = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_write(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + 1;
    e.a   = a;
    e.d   = d;
    sb.push_back(e);
    exp_rf[a] = d;
  endtask

  // Evaluated just before the edge: predict the grant, compare it and advance the model.
  task automatic model_eval();
    logic [2:0] exp_rdy;
    int g;
    exp_rdy = '0;
    g = -1;
    if (model_ok) begin
      check("init_busy", 32'(init_busy), 32'(m_init));
      if (init_busy) busy_cnt++;
    end
    if (rst) begin
      m_init = 1'b0; m_cnt = 0; m_ptr = 0;
      for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    end else if (!m_init) begin
      if (init_go) begin
        m_init = 1'b1; m_cnt = 0;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (m_ptr + k) % NREQ;
          if (g < 0 && pend_v[j]) g = j;
        end
        if (g >= 0) begin
          exp_rdy[g] = 1'b1;
          push_write(pend_a[g], pend_d[g]);
          pend_v[g] = 1'b0;
          m_ptr = (g + 1) % NREQ;
        end
      end
    end else begin
      push_write(5'(m_cnt), 32'(m_cnt));
      if (m_cnt == 31) m_init = 1'b0;
      m_cnt = (m_cnt + 1) % 32;
    end
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) glog.push_back(i);
    if (z_chk) check("z_req_ready", 32'(z_ready), 32'(z_exp_rdy));
  endtask

  task automatic tick();
    init_start = init_go;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = pend_v[i];
      req_addr[i*5 +: 5]   = pend_a[i];
      req_data[i*32 +: 32] = pend_d[i];
    end
    #4;
    model_eval();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_one(input int i, input logic [4:0] a, input logic [31:0] d);
    pend_v[i] = 1'b1; pend_a[i] = a; pend_d[i] = d;
    for (int t = 0; t < 20 && pend_v[i]; t++) tick();
    check("write_granted", 32'(pend_v[i]), 32'd0);
  endtask

  // Write-port monitor: every WE3 pulse must match the oldest expected write in its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (model_ok) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        check("we3_missed_write_cycle", 32'(cyc), 32'(e.cyc));
      end
      if (WE3) begin
        we_cnt++;
        dut_rf[A3] = WD3;
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          check("we3_unexpected", 32'(WE3), 32'd0);
        end else begin
          e = sb.pop_front();
          check("A3", 32'(A3), 32'(e.a));
          check("WD3", WD3, e.d);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      exp_rf[i] = 32'(i);
      dut_rf[i] = 32'(i);
    end
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0; pend_a[i] = '0; pend_d[i] = '0;
    end
    @(negedge clk);
    do_reset();
    do_reset();
    model_ok = 1'b1;
    check("reset_WE3", 32'(WE3), 32'd0);
    check("reset_A3", 32'(A3), 32'd0);
    check("reset_WD3", WD3, 32'd0);
    check("reset_init_busy", 32'(init_busy), 32'd0);

    // ZERO_X0 instance: address 0 is consumed without a write, pointer still advances.
    z_chk = 1'b1;
    z_valid = 3'b001; z_addr[4:0] = 5'd0; z_data[31:0] = 32'h1234; z_exp_rdy = 3'b001;
    tick();
    z_valid = 3'b000; z_exp_rdy = 3'b000;
    check("z_we_addr0", 32'(z_we), 32'd0);
    tick();
    z_valid = 3'b011; z_addr[9:5] = 5'd3; z_data[63:32] = 32'h55; z_exp_rdy = 3'b010;
    tick();
    check("z_we_after_ptr", 32'(z_we), 32'd1);
    check("z_a3", 32'(z_a3), 32'd3);
    check("z_wd3", z_wd3, 32'h55);
    z_valid = 3'b001; z_exp_rdy = 3'b001;
    tick();
    z_valid = 3'b000; z_exp_rdy = 3'b000;
    check("z_we_addr0_again", 32'(z_we), 32'd0);
    tick();
    z_chk = 1'b0;

    // Single requester.
    pend_v[0] = 1'b1; pend_a[0] = 5'd5; pend_d[0] = 32'hDEADBEEF;
    tick();
    check("single_granted", 32'(pend_v[0]), 32'd0);
    tick(); tick();
    check("rf5_readback", dut_rf[5], 32'hDEADBEEF);

    // Round-robin fairness with all requesters continuously valid.
    do_reset();
    glog.delete();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NREQ; i++) if (!pend_v[i]) begin
        pend_v[i] = 1'b1; pend_a[i] = 5'(20 + i); pend_d[i] = $urandom;
      end
      tick();
    end
    check("rr_grant_count", 32'(glog.size()), 32'd6);
    for (int n = 0; n < 6 && n < glog.size(); n++) check("rr_order", 32'(glog[n]), 32'(n % 3));

    // Corrupt every register, then restore with init (a second init_start mid-sequence is ignored).
    do_reset();
    for (int a = 0; a < 32; a++) write_one(a % 3, 5'(a), 32'hFFFFFFFF);
    tick();
    we_cnt = 0; busy_cnt = 0;
    init_go = 1'b1; tick(); init_go = 1'b0;
    for (int n = 0; n < 36; n++) begin
      init_go = (n == 5);
      tick();
    end
    init_go = 1'b0;
    check("init_we3_pulses", 32'(we_cnt), 32'd32);
    check("init_busy_cycles", 32'(busy_cnt), 32'd32);
    for (int i = 0; i < 32; i++) check("init_rf_value", dut_rf[i], 32'(i));

    // Request arriving mid-init waits for the first ARB cycle.
    init_go = 1'b1; tick(); init_go = 1'b0;
    repeat (3) tick();
    pend_v[1] = 1'b1; pend_a[1] = 5'd9; pend_d[1] = $urandom;
    repeat (40) tick();
    check("init_req_granted", 32'(pend_v[1]), 32'd0);

    // Randomized traffic with occasional init and reset.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++) if (!pend_v[i] && $urandom_range(1, 0) == 1) begin
        pend_v[i] = 1'b1; pend_a[i] = 5'($urandom_range(31, 0)); pend_d[i] = $urandom;
      end
      init_go = ($urandom_range(39, 0) == 0);
      rst     = ($urandom_range(299, 0) == 0);
      tick();
    end
    init_go = 1'b0; rst = 1'b0;

    // Reset at init cycle 10 aborts the sequence.
    do_reset();
    for (int a = 0; a < 32; a++) write_one(a % 3, 5'(a), 32'hFFFFFFFF);
    tick();
    init_go = 1'b1; tick(); init_go = 1'b0;
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort_WE3", 32'(WE3), 32'd0);
    check("abort_init_busy", 32'(init_busy), 32'd0);
    for (int n = 0; n < 3; n++) begin
      tick();
      check("abort_WE3_after", 32'(WE3), 32'd0);
    end
    for (int i = 0; i < 32; i++)
      check("abort_rf_value", dut_rf[i], (i < 10) ? 32'(i) : 32'hFFFFFFFF);

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 32; i++) check("final_rf", dut_rf[i], exp_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
